dpbram_rd_stream: RTL and testbench
===================================

# dpbram_rd_stream

Read-side companion of the true dual-port BRAM: walks a contiguous address window on one BRAM port and converts the 1-cycle read latency into a valid/ready stream for the FC core datapath. It sits between the BRAM port 1 (read-only use) and the MAC/accumulate stage. It sustains one word per clock under no backpressure and never loses a word when the consumer stalls.

## Interface
- DWIDTH, 16, data width; equals BRAM DWIDTH
- AWIDTH, 12, address width; equals BRAM AWIDTH
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_run  in  1  start pulse; sampled only in IDLE
- i_base_addr  in  AWIDTH  first read address; latched on accepted i_run
- i_num  in  AWIDTH  number of words to read; latched on accepted i_run; 0 allowed
- o_idle  out  1  high in IDLE
- o_running  out  1  high in RUN
- o_done  out  1  one-cycle pulse in DONE
- o_addr  out  AWIDTH  BRAM address
- o_ce  out  1  BRAM chip enable (read strobe)
- o_we  out  1  BRAM write enable; constant 0
- i_q  in  DWIDTH  BRAM read data; valid the cycle after o_ce=1
- o_valid  out  1  stream data valid
- o_data  out  DWIDTH  stream data
- i_ready  in  1  consumer ready; transfer when o_valid & i_ready

## Operation
- FSM: IDLE -> RUN on i_run; RUN -> DONE when delivered count == latched num; DONE -> IDLE unconditionally. i_run with i_num=0: IDLE -> DONE directly (no o_ce, no o_valid).
- i_run outside IDLE ignored; base/num latches unchanged.
- Counters: issue_cnt (reads issued) and out_cnt (handshakes), both AWIDTH+1 bits, cleared on accepted i_run.
- Read address = (base + issue_cnt) mod 2^AWIDTH; wrap at 2^AWIDTH is silent, no error.
- Output buffer: 2-entry FIFO of DWIDTH words; in-flight flag marks a read issued last cycle; i_q is written into FIFO the cycle after o_ce.
- Issue rule (RUN only): o_ce=1 when issue_cnt < num and (fifo_cnt + inflight < 2, or fifo_cnt + inflight == 2 and a handshake occurs this cycle). Guarantees FIFO never overflows.
- o_addr holds its last value when o_ce=0; o_we always 0.
- o_valid = FIFO not empty; o_data = FIFO head; pop on handshake.
- Simultaneous push (i_q arrival) and pop: count unchanged, order preserved.
- o_done pulses in the DONE cycle; o_valid is 0 there (all words delivered).
- Reset (any state, including mid-transfer): state IDLE, counters 0, FIFO flushed, inflight cleared; a BRAM return in the cycle after reset is discarded.

## Timing
- Reset values: o_idle=1, o_running=0, o_done=0, o_ce=0, o_we=0, o_addr=0, o_valid=0, o_data=0.
- Cycle N: i_run sampled in IDLE. N+1: RUN, o_ce=1, o_addr=base. N+2: i_q valid, written to FIFO. N+3: o_valid=1, o_data=mem[base].
- With i_ready held 1: one word per cycle; last word (index num-1) handshaked at N+2+num; o_done at N+3+num; o_idle at N+4+num.
- i_num=0: o_done at N+1, IDLE at N+2.
- Backpressure: after i_ready drops, at most 2 words held (FIFO full, no further o_ce); on i_ready rising, stream resumes same cycle with no gap and no duplicate.
- o_data stable while o_valid=1 and i_ready=0.

## Test plan
- Basic: mem[k]=k+0x100, base=0x010, num=8, i_ready=1 -> o_ce at N+1..N+8, o_data 0x110..0x117 at N+3..N+10, o_done at N+11.
- Backpressure: same setup, i_ready=0 for cycles N+4..N+9 -> no more than 2 reads outstanding+buffered, o_data held, full sequence 0x110..0x117 delivered once, in order.
- Random ready: num=100, i_ready random 50% -> exactly 100 handshakes, data matches mem[base+i], o_ce count = 100.
- Wrap and zero: base=0xFFE, num=4 -> addresses 0xFFE,0xFFF,0x000,0x001; then i_num=0 -> o_done at N+1, o_ce never asserted.
- Reset mid-op: assert reset at 3rd handshake of num=8 -> next cycle all outputs at reset values, no o_valid from flushed/in-flight data; new run with base=0x020,num=2 delivers mem[0x20],mem[0x21] correctly.
- Ignored start: pulse i_run with different base during RUN -> no effect on addresses or count.

Source files
------------

// File: rtl/dpbram_rd_stream.sv
// Streams a contiguous BRAM address window out of a 1-cycle-latency read port
// as a valid/ready stream, buffering returns in a 2-entry skid FIFO.
module dpbram_rd_stream #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic [AWIDTH-1:0] i_base_addr,
  input  logic [AWIDTH-1:0] i_num,
  output logic              o_idle,
  output logic              o_running,
  output logic              o_done,
  output logic [AWIDTH-1:0] o_addr,
  output logic              o_ce,
  output logic              o_we,
  input  logic [DWIDTH-1:0] i_q,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data,
  input  logic              i_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   base_q, num_q, addr_q;
  logic [AWIDTH:0]     issue_cnt_q, out_cnt_q, out_cnt_d;
  logic                inflight_q;
  logic [1:0]          fifo_cnt_q;
  logic                wr_ptr_q, rd_ptr_q;
  logic [DWIDTH-1:0]   fifo_q [2];

  logic                start, hs, push, ce;
  logic [1:0]          occ;

  assign start = (state_q == S_IDLE) && i_run;
  assign hs    = o_valid && i_ready;
  assign push  = inflight_q;
  assign occ   = fifo_cnt_q + {1'b0, inflight_q};

  always_comb begin
    state_d   = state_q;
    ce        = 1'b0;
    out_cnt_d = out_cnt_q + {{AWIDTH{1'b0}}, hs};
    case (state_q)
      S_IDLE: begin
        if (i_run) state_d = (i_num == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        // A slot frees this cycle when the head is popped, so a full
        // pipeline can still issue under a handshake without overflowing.
        ce = (issue_cnt_q < {1'b0, num_q}) &&
             ((occ < 2'd2) || ((occ == 2'd2) && hs));
        if (out_cnt_d == {1'b0, num_q}) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ce      = ce;
  assign o_we      = 1'b0;
  assign o_addr    = ce ? (base_q + issue_cnt_q[AWIDTH-1:0]) : addr_q;
  assign o_idle    = (state_q == S_IDLE);
  assign o_running = (state_q == S_RUN);
  assign o_done    = (state_q == S_DONE);
  assign o_valid   = (fifo_cnt_q != 2'd0);
  assign o_data    = o_valid ? fifo_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= o_addr;
      inflight_q <= ce;
      if (start) begin
        base_q      <= i_base_addr;
        num_q       <= i_num;
        issue_cnt_q <= '0;
        out_cnt_q   <= '0;
      end else begin
        if (ce) issue_cnt_q <= issue_cnt_q + CNT_ONE;
        if (hs) out_cnt_q <= out_cnt_d;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (hs)   rd_ptr_q <= ~rd_ptr_q;
      case ({push, hs})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Storage only; occupancy is tracked by fifo_cnt_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= i_q;
  end

endmodule

// File: tb/tb_dpbram_rd_stream.sv
// Randomized scoreboard bench for dpbram_rd_stream: expected addresses/data are
// queued per job from a memory array, and a negedge monitor pops and compares.
module tb_dpbram_rd_stream;
  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_run = 1'b0;
  logic          i_ready = 1'b1;
  logic [AW-1:0] i_base_addr = '0;
  logic [AW-1:0] i_num = '0;
  logic [DW-1:0] i_q = '0;
  logic          o_idle, o_running, o_done, o_ce, o_we, o_valid;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;

  dpbram_rd_stream #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_base_addr(i_base_addr),
    .i_num(i_num), .o_idle(o_idle), .o_running(o_running), .o_done(o_done),
    .o_addr(o_addr), .o_ce(o_ce), .o_we(o_we), .i_q(i_q), .o_valid(o_valid),
    .o_data(o_data), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [1 << AW];
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_data_q [$];

  int n_checks = 0;
  int n_err = 0;
  int ready_mode = 0;
  int start_cyc = 0;
  int ce_job = 0, hs_job = 0, ce_tot = 0, hs_tot = 0, max_occ = 0;
  int done_seen = 0, done_cyc = -1, first_valid_cyc = -1, we_hits = 0;
  bit hold_pending = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [AW-1:0] mon_a;
  logic [DW-1:0] mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // BRAM model: data for a read strobe appears the following cycle; otherwise garbage.
  initial begin
    logic          ce_s;
    logic [AW-1:0] a_s;
    forever begin
      @(negedge clk);
      ce_s = o_ce;
      a_s  = o_addr;
      @(posedge clk);
      #1;
      i_q = ce_s ? mem[a_s] : DW'($urandom);
    end
  end

  // Consumer ready pattern: 0 always ready, 1 random, 2 stall window N+4..N+9.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       i_ready = 1'($urandom);
        2:       i_ready = !(cyc >= start_cyc + 4 && cyc <= start_cyc + 9);
        default: i_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (ce_tot - hs_tot > max_occ) max_occ = ce_tot - hs_tot;
      if (o_we) we_hits++;
      if (hold_pending) begin
        check("hold_valid", 32'(o_valid), 32'd1);
        check("hold_data", 32'(o_data), 32'(hold_data));
      end
      if (o_ce) begin
        ce_job++;
        ce_tot++;
        check("read_expected", 32'(exp_addr_q.size() > 0), 32'd1);
        if (exp_addr_q.size() > 0) begin
          mon_a = exp_addr_q.pop_front();
          check("read_addr", 32'(o_addr), 32'(mon_a));
        end
      end
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_valid && i_ready) begin
        hs_job++;
        hs_tot++;
        check("data_expected", 32'(exp_data_q.size() > 0), 32'd1);
        if (exp_data_q.size() > 0) begin
          mon_d = exp_data_q.pop_front();
          check("stream_data", 32'(o_data), 32'(mon_d));
        end
      end
      if (o_done) begin
        done_seen++;
        done_cyc = cyc;
        check("valid_in_done", 32'(o_valid), 32'd0);
      end
      hold_pending = o_valid && !i_ready;
      hold_data    = o_data;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"}, 32'(o_idle), 32'd1);
    check({tag, "_running"}, 32'(o_running), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_ce"}, 32'(o_ce), 32'd0);
    check({tag, "_we"}, 32'(o_we), 32'd0);
    check({tag, "_addr"}, 32'(o_addr), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_data"}, 32'(o_data), 32'd0);
  endtask

  task automatic start_job(input logic [AW-1:0] base, input int num, input int mode);
    for (int i = 0; i < num; i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
    end
    @(posedge clk);
    #1;
    ready_mode      = mode;
    i_base_addr     = base;
    i_num           = AW'(num);
    i_run           = 1'b1;
    start_cyc       = cyc;
    ce_job          = 0;
    hs_job          = 0;
    max_occ         = 0;
    done_seen       = 0;
    done_cyc        = -1;
    first_valid_cyc = -1;
    @(posedge clk);
    #1;
    i_run       = 1'b0;
    i_base_addr = AW'($urandom);
    i_num       = AW'($urandom);
  endtask

  task automatic run_job(input logic [AW-1:0] base, input int num, input int mode, input bit poke);
    int budget;
    start_job(base, num, mode);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      i_run       = 1'b1;
      i_base_addr = base + 12'h123;
      i_num       = AW'(3);
      @(posedge clk);
      #1;
      i_run = 1'b0;
    end
    budget = 0;
    while (done_seen == 0 && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    check("done_seen", 32'(done_seen), 32'd1);
    @(negedge clk);
    check("idle_after_done", 32'(o_idle), 32'd1);
    check("handshake_count", 32'(hs_job), 32'(num));
    check("read_count", 32'(ce_job), 32'(num));
    check("leftover_words", 32'(exp_data_q.size()), 32'd0);
    check("occupancy_le2", 32'(max_occ <= 2), 32'd1);
    if (mode == 0) begin
      check("done_latency", 32'(done_cyc - start_cyc), 32'((num == 0) ? 1 : 3 + num));
      if (num > 0) check("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd3);
    end
    $display("job base=0x%03h num=%0d mode=%0d poke=%0d reads=%0d handshakes=%0d errors=%0d",
             base, num, mode, poke, ce_job, hs_job, n_err);
  endtask

  task automatic reset_midop();
    int budget;
    start_job(12'h040, 8, 0);
    budget = 0;
    while (hs_job < 3 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    check("third_handshake", 32'(hs_job >= 3), 32'd1);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    ce_tot = 0;
    hs_tot = 0;
    @(negedge clk);
    check_reset_outputs("midop_reset");
    @(negedge clk);
    check("post_reset_valid", 32'(o_valid), 32'd0);
    check("post_reset_ce", 32'(o_ce), 32'd0);
    $display("job reset asserted mid-transfer after %0d handshakes", hs_job);
    run_job(12'h020, 2, 0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < (1 << AW); k++) mem[k] = DW'(k + 16'h100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("init_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_job(12'h010, 8, 0, 1'b0);
    run_job(12'h010, 8, 2, 1'b0);
    run_job(12'hFFE, 4, 0, 1'b0);
    run_job(12'h555, 0, 0, 1'b0);
    run_job(12'h300, 20, 0, 1'b1);
    reset_midop();

    for (int k = 0; k < (1 << AW); k++) mem[k] = DW'($urandom);
    run_job(AW'($urandom), 100, 1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      run_job(AW'($urandom), int'($urandom_range(0, 40)), 1, 1'b0);
    end
    run_job(12'hFF0, 30, 1, 1'b1);

    check("we_never_high", 32'(we_hits), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
